// File: rtl/serial_add_sequencer.sv
// rtl/serial_add_sequencer.sv - bit-serial add/sub sequencer around one full adder (option: SERIAL_SUBTRACT_EN)

module full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_s,
    output logic o_co
);
    assign o_s  = i_a ^ i_b ^ i_c;
    assign o_co = (i_a & i_b) | (i_c & (i_a ^ i_b));
endmodule

module serial_add_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_SUBTRACT_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    logic [WIDTH-1:0]   r_res_sh;
    logic               r_c;
    logic               r_inv;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_result;
    logic               r_carry;
    logic               r_zero;

    logic               w_sub;
    logic               w_s;
    logic               w_co;
    logic [WIDTH-1:0]   w_res_next;

`ifdef SERIAL_SUBTRACT_EN
    assign w_sub = sub;
`else
    assign w_sub = 1'b0;
`endif

    full_adder u_fa (
        .i_a  (r_a_sh[0]),
        .i_b  (r_b_sh[0] ^ r_inv),
        .i_c  (r_c),
        .o_s  (w_s),
        .o_co (w_co)
    );

    assign w_res_next = {w_s, r_res_sh[WIDTH-1:1]};

    // Outputs are captured on the last RUN edge so they are already valid in the DONE cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_res_sh <= '0;
            r_c      <= 1'b0;
            r_inv    <= 1'b0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
            r_carry  <= 1'b0;
            r_zero   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a_sh  <= a;
                        r_b_sh  <= b;
                        r_inv   <= w_sub;
                        r_c     <= w_sub;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_res_sh <= w_res_next;
                    r_a_sh   <= r_a_sh >> 1;
                    r_b_sh   <= r_b_sh >> 1;
                    r_c      <= w_co;
                    r_cnt    <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(WIDTH - 1)) begin
                        r_result <= w_res_next;
                        r_carry  <= w_co;
                        r_zero   <= (w_res_next == '0);
                        r_done   <= 1'b1;
                        r_state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;
    assign carry  = r_carry;
    assign zero   = r_zero;
endmodule

// File: tb/tb_serial_add_sequencer.sv
// tb/tb_serial_add_sequencer.sv - directed self-checking bench for serial_add_sequencer (WIDTH=8)

module tb_serial_add_sequencer;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       sub = 1'b0;
    logic       busy, done, carry, zero;
    logic [7:0] result;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_add_sequencer #(.WIDTH(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
`ifdef SERIAL_SUBTRACT_EN
        .sub    (sub),
`endif
        .busy   (busy),
        .done   (done),
        .result (result),
        .carry  (carry),
        .zero   (zero)
    );

    // Pulses start for one cycle and returns the cycle index (1 = first cycle after acceptance) of done, -1 on timeout.
    task automatic run_op(input logic [7:0] ia, input logic [7:0] ib, input logic is, output int lat);
        @(negedge clk);
        a = ia; b = ib; sub = is; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = -1;
        for (int i = 1; i <= 30; i++) begin
            if (done) begin
                lat = i;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, result, carry, zero} !== 12'h000) begin
            errors++;
            $display("FAIL reset: busy=%b done=%b result=%h carry=%b zero=%b, required all 0",
                     busy, done, result, carry, zero);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_add;
        int busy_cnt = 0;
        int lat = -1;
        @(negedge clk);
        a = 8'h03; b = 8'h05; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            if (busy) busy_cnt++;
            if (done && lat < 0) lat = i;
            if (i == 9) begin
                checks++;
                if (result !== 8'h08 || carry !== 1'b0 || zero !== 1'b0) begin
                    errors++;
                    $display("FAIL add_value: result=%h carry=%b zero=%b, required 08 0 0", result, carry, zero);
                end
            end
            if (i == 10) begin
                checks++;
                if (done !== 1'b0 || busy !== 1'b0) begin
                    errors++;
                    $display("FAIL add_pulse: done=%b busy=%b after done cycle, required 0 0", done, busy);
                end
            end
            @(negedge clk);
        end
        checks++;
        if (lat != 9) begin
            errors++;
            $display("FAIL add_latency: done at cycle %0d, required 9", lat);
        end
        checks++;
        if (busy_cnt != 9) begin
            errors++;
            $display("FAIL add_busy: busy cycles %0d, required 9", busy_cnt);
        end
        checks++;
        if (result !== 8'h08) begin
            errors++;
            $display("FAIL add_hold: result=%h, required 08", result);
        end
    endtask

    task automatic test_wrap;
        int lat;
        run_op(8'hFF, 8'h01, 1'b0, lat);
        checks++;
        if (lat != 9 || result !== 8'h00 || carry !== 1'b1 || zero !== 1'b1) begin
            errors++;
            $display("FAIL wrap_ff_01: lat=%0d result=%h carry=%b zero=%b, required 9 00 1 1", lat, result, carry, zero);
        end
        run_op(8'hFF, 8'hFF, 1'b0, lat);
        checks++;
        if (lat != 9 || result !== 8'hFE || carry !== 1'b1 || zero !== 1'b0) begin
            errors++;
            $display("FAIL wrap_ff_ff: lat=%0d result=%h carry=%b zero=%b, required 9 FE 1 0", lat, result, carry, zero);
        end
        run_op(8'hA5, 8'h5A, 1'b0, lat);
        checks++;
        if (result !== 8'hFF || carry !== 1'b0 || zero !== 1'b0) begin
            errors++;
            $display("FAIL add_a5_5a: result=%h carry=%b zero=%b, required FF 0 0", result, carry, zero);
        end
    endtask

    task automatic test_busy;
        int pulses = 0;
        int lat = -1;
        @(negedge clk);
        a = 8'h03; b = 8'h05; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 1; i <= 25; i++) begin
            if (i == 3) begin
                a = 8'h10; b = 8'h10; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                pulses++;
                if (lat < 0) lat = i;
            end
            @(negedge clk);
        end
        checks++;
        if (pulses != 1 || lat != 9) begin
            errors++;
            $display("FAIL busy_ignore: %0d done pulses first at %0d, required 1 at 9", pulses, lat);
        end
        checks++;
        if (result !== 8'h08) begin
            errors++;
            $display("FAIL busy_result: result=%h, required 08", result);
        end
    endtask

    task automatic test_reset_mid;
        int pulses = 0;
        int lat;
        @(negedge clk);
        a = 8'h77; b = 8'h11; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({busy, done, result, carry, zero} !== 12'h000) begin
            errors++;
            $display("FAIL reset_mid: busy=%b done=%b result=%h carry=%b zero=%b, required all 0",
                     busy, done, result, carry, zero);
        end
        for (int i = 0; i < 15; i++) begin
            if (done) pulses++;
            @(negedge clk);
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL reset_mid_nodone: %0d done pulses, required 0", pulses);
        end
        run_op(8'h22, 8'h11, 1'b0, lat);
        checks++;
        if (lat != 9 || result !== 8'h33 || carry !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_next: lat=%0d result=%h carry=%b, required 9 33 0", lat, result, carry);
        end
    endtask

    task automatic test_back_to_back;
        int first = -1;
        int second = -1;
        @(negedge clk);
        a = 8'h12; b = 8'h34; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        for (int i = 1; i <= 19; i++) begin
            if (done) begin
                if (first < 0) first = i;
                else if (second < 0) second = i;
            end
            if (i < 19) @(negedge clk);
        end
        start = 1'b0;
        checks++;
        if (first != 9 || second != 19) begin
            errors++;
            $display("FAIL b2b_timing: done at %0d and %0d, required 9 and 19", first, second);
        end
        checks++;
        if (result !== 8'h46) begin
            errors++;
            $display("FAIL b2b_result: result=%h, required 46", result);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: busy=%b, required 0", busy);
        end
    endtask

`ifdef SERIAL_SUBTRACT_EN
    task automatic test_subtract;
        int lat;
        run_op(8'h05, 8'h03, 1'b1, lat);
        checks++;
        if (lat != 9 || result !== 8'h02 || carry !== 1'b1 || zero !== 1'b0) begin
            errors++;
            $display("FAIL sub_5_3: lat=%0d result=%h carry=%b zero=%b, required 9 02 1 0", lat, result, carry, zero);
        end
        run_op(8'h03, 8'h05, 1'b1, lat);
        checks++;
        if (result !== 8'hFE || carry !== 1'b0) begin
            errors++;
            $display("FAIL sub_3_5: result=%h carry=%b, required FE 0", result, carry);
        end
        run_op(8'h40, 8'h40, 1'b1, lat);
        checks++;
        if (result !== 8'h00 || zero !== 1'b1 || carry !== 1'b1) begin
            errors++;
            $display("FAIL sub_40_40: result=%h zero=%b carry=%b, required 00 1 1", result, zero, carry);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_add();
        test_wrap();
        test_busy();
        test_reset_mid();
        test_back_to_back();
`ifdef SERIAL_SUBTRACT_EN
        test_subtract();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
